fetch_ctrl: RTL and testbench
=============================

FETCH_CTRL -- requirements
Module: fetch_ctrl

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, SHALL be the first fetch address after reset.
REQ-002 clk  input  1  clock; all state SHALL update on the rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 PCsrcE  input  1  redirect request from Execute (branch/jump taken).
REQ-005 PCplusImmE  input  32  redirect target.
REQ-006 stallD  input  1  Decode stall; IF/ID contents SHALL hold.
REQ-007 imemReq  output  1  instruction-memory request.
REQ-008 imemAddr  output  32  request address.
REQ-009 imemReady  input  1  memory accepts the request and returns data in the same cycle.
REQ-010 imemRdata  input  32  instruction data, valid when imemReq && imemReady.
REQ-011 instrD  output  32  IF/ID instruction.
REQ-012 PCD  output  32  IF/ID PC.
REQ-013 validD  output  1  IF/ID holds a real instruction.

Function
REQ-014 States SHALL be IDLE, REQ, DISCARD and HOLD; the encoding is internal.
REQ-015 IDLE SHALL last exactly one cycle after reset release and then go to REQ with imemAddr=RESET_PC.
REQ-016 Handshake: once imemReq rises, imemReq and imemAddr SHALL stay stable until a cycle with imemReady=1.
REQ-017 In REQ, a ready cycle with no stall and no redirect SHALL load IF/ID next edge (validD=1, PCD=imemAddr, instrD=imemRdata) and advance pc by 4 (mod 2^32, 32'hFFFF_FFFC wraps to 0).
REQ-018 Back-to-back fetch: imemReq SHALL stay high after a completed handshake, giving a throughput of 1 instruction/cycle and a latency of 1 cycle from ready to instrD.
REQ-019 stallD=1: IF/ID SHALL hold, and no new request SHALL be launched after an in-flight handshake completes.
REQ-020 A response arriving while stallD=1 SHALL go to the 1-entry skid buffer, state HOLD, imemReq=0.
REQ-021 HOLD with stallD=0 SHALL move the skid entry into IF/ID and return to REQ in the same edge.
REQ-022 PCsrcE=1 SHALL take priority over stallD and over any pending response.
  - On the next edge: pc<=PCplusImmE, IF/ID flushed (instrD=0, PCD=0, validD=0), skid emptied.
REQ-023 Redirect while a request is outstanding (imemReady=0) SHALL go to DISCARD.
  - imemReq and the old imemAddr stay held until ready; that response is dropped; the next cycle goes to REQ at the target.
REQ-024 Redirect in the same cycle as imemReady=1 SHALL drop that data, skip DISCARD, and request the target next cycle.
REQ-025 Redirect while in DISCARD SHALL update the pending target only; the last PCsrcE wins.

Reset
REQ-026 rst=1 SHALL immediately force the following, regardless of state or an in-flight handshake:
  - state=IDLE, pc=RESET_PC, imemReq=0, imemAddr=RESET_PC
  - instrD=0, PCD=0, validD=0, skid empty
  - performance counters (if present) = 0

Configuration
REQ-027 Macro FETCH_PERF_EN SHALL add two 32-bit saturating outputs:
  - perfBubbleCnt: cycles with validD=0 after IDLE
  - perfDropCnt: responses dropped by REQ-023/024
REQ-028 Without FETCH_PERF_EN, neither port nor its logic SHALL exist; all other behaviour is identical.

Structure
REQ-029 A shared package SHALL hold the state typedef, BUBBLE_INSTR=32'h0 and PC_STEP=32'd4.
REQ-030 The skid buffer SHALL be the sub-module fetch_skid (32-bit instr + 32-bit PC + valid, load/unload/clear).

Verification
REQ-031 Reset release, imemReady tied 1 -> imemAddr 0,4,8,C on consecutive cycles; PCD lags imemAddr by 1 cycle; validD=1 from cycle 2.
REQ-032 imemReady low 3 cycles at addr 0x10 -> imemReq/imemAddr stable for 4 cycles; instrD=imemRdata the cycle after ready.
REQ-033 stallD high 2 cycles while addr 0x20 completes -> HOLD, imemReq=0; after release PCD=0x20, then request 0x24.
REQ-034 PCsrcE=1, PCplusImmE=0x100 while 0x30 outstanding, ready 2 cycles later -> 0x30 data never reaches instrD; next request 0x100; validD=0 during the gap.
REQ-035 PCsrcE=1 with stallD=1 and skid full -> flush wins; skid cleared; next imemAddr=target.
REQ-036 rst pulsed mid-handshake -> all outputs 0 immediately; fetch restarts at RESET_PC; with FETCH_PERF_EN the counters read 0.

Source files
------------

// File: rtl/fetch_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// fetch_ctrl_pkg : shared state type and constants for the fetch controller
// Rev 1.0
// ============================================================================
package fetch_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_REQ     = 2'd1,
    ST_DISCARD = 2'd2,
    ST_HOLD    = 2'd3
  } fetch_state_e;

  localparam logic [31:0] BUBBLE_INSTR = 32'h0000_0000;
  localparam logic [31:0] PC_STEP      = 32'd4;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/fetch_skid.sv
`default_nettype none
// ============================================================================
// fetch_skid : one-entry instruction/PC skid buffer (load/unload/clear)
// Rev 1.0
// ============================================================================
module fetch_skid
  import fetch_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic        unload,
  input  logic        clear,
  input  logic [31:0] instr_in,
  input  logic [31:0] pc_in,
  output logic [31:0] instr,
  output logic [31:0] pc,
  output logic        valid
);

  logic [31:0] instr_q, instr_d;
  logic [31:0] pc_q, pc_d;
  logic        valid_q, valid_d;

  always_comb begin
    instr_d = instr_q;
    pc_d    = pc_q;
    valid_d = valid_q;
    if (clear) begin
      instr_d = BUBBLE_INSTR;
      pc_d    = '0;
      valid_d = 1'b0;
    end else if (load) begin
      instr_d = instr_in;
      pc_d    = pc_in;
      valid_d = 1'b1;
    end else if (unload) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      instr_q <= BUBBLE_INSTR;
      pc_q    <= '0;
      valid_q <= 1'b0;
    end else begin
      instr_q <= instr_d;
      pc_q    <= pc_d;
      valid_q <= valid_d;
    end
  end

  assign instr = instr_q;
  assign pc    = pc_q;
  assign valid = valid_q;

endmodule
`default_nettype wire

// File: rtl/fetch_ctrl.sv
`default_nettype none
// ============================================================================
// fetch_ctrl : instruction fetch controller with IF/ID register and skid
// Optional macro FETCH_PERF_EN adds bubble/drop saturating counters.
// Rev 1.0
// ============================================================================
module fetch_ctrl
  import fetch_ctrl_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        PCsrcE,
  input  logic [31:0] PCplusImmE,
  input  logic        stallD,
  output logic        imemReq,
  output logic [31:0] imemAddr,
  input  logic        imemReady,
  input  logic [31:0] imemRdata,
  output logic [31:0] instrD,
  output logic [31:0] PCD,
  output logic        validD
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0] perfBubbleCnt,
  output logic [31:0] perfDropCnt
`endif
);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  target_q, target_d;
  logic         req_q, req_d;
  logic [31:0]  instr_q, instr_d;
  logic [31:0]  pcd_q, pcd_d;
  logic         valid_q, valid_d;

  logic         skid_load, skid_unload, skid_clear;
  logic [31:0]  skid_instr, skid_pc;
  logic         skid_valid;

  fetch_skid u_skid (
    .clk      (clk),
    .rst      (rst),
    .load     (skid_load),
    .unload   (skid_unload),
    .clear    (skid_clear),
    .instr_in (imemRdata),
    .pc_in    (pc_q),
    .instr    (skid_instr),
    .pc       (skid_pc),
    .valid    (skid_valid)
  );

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    target_d    = target_q;
    req_d       = req_q;
    instr_d     = instr_q;
    pcd_d       = pcd_q;
    valid_d     = valid_q;
    skid_load   = 1'b0;
    skid_unload = 1'b0;
    skid_clear  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        state_d = ST_REQ;
        req_d   = 1'b1;
        if (PCsrcE) pc_d = PCplusImmE;
      end
      ST_REQ: begin
        if (PCsrcE) begin
          if (imemReady) begin
            pc_d = PCplusImmE;
          end else begin
            // Old address must stay on the bus until the memory answers
            state_d  = ST_DISCARD;
            target_d = PCplusImmE;
          end
        end else if (imemReady) begin
          pc_d = pc_q + PC_STEP;
          if (stallD) begin
            skid_load = 1'b1;
            state_d   = ST_HOLD;
            req_d     = 1'b0;
          end else begin
            instr_d = imemRdata;
            pcd_d   = pc_q;
            valid_d = 1'b1;
          end
        end else if (!stallD) begin
          instr_d = BUBBLE_INSTR;
          pcd_d   = '0;
          valid_d = 1'b0;
        end
      end
      ST_DISCARD: begin
        if (PCsrcE) target_d = PCplusImmE;
        if (imemReady) begin
          state_d = ST_REQ;
          pc_d    = PCsrcE ? PCplusImmE : target_q;
        end
      end
      ST_HOLD: begin
        if (PCsrcE) begin
          pc_d    = PCplusImmE;
          state_d = ST_REQ;
          req_d   = 1'b1;
        end else if (!stallD) begin
          instr_d     = skid_instr;
          pcd_d       = skid_pc;
          valid_d     = skid_valid;
          skid_unload = 1'b1;
          state_d     = ST_REQ;
          req_d       = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // A redirect overrides every other IF/ID and skid update
    if (PCsrcE) begin
      instr_d    = BUBBLE_INSTR;
      pcd_d      = '0;
      valid_d    = 1'b0;
      skid_clear = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      pc_q     <= RESET_PC;
      target_q <= RESET_PC;
      req_q    <= 1'b0;
      instr_q  <= BUBBLE_INSTR;
      pcd_q    <= '0;
      valid_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      target_q <= target_d;
      req_q    <= req_d;
      instr_q  <= instr_d;
      pcd_q    <= pcd_d;
      valid_q  <= valid_d;
    end
  end

  assign imemReq  = req_q;
  assign imemAddr = pc_q;
  assign instrD   = instr_q;
  assign PCD      = pcd_q;
  assign validD   = valid_q;

`ifdef FETCH_PERF_EN
  logic [31:0] bubble_cnt_q, bubble_cnt_d;
  logic [31:0] drop_cnt_q, drop_cnt_d;
  logic        drop_evt;

  assign drop_evt = imemReady &&
                    ((state_q == ST_REQ && PCsrcE) || state_q == ST_DISCARD);

  always_comb begin
    bubble_cnt_d = bubble_cnt_q;
    drop_cnt_d   = drop_cnt_q;
    if (state_q != ST_IDLE && !valid_q) bubble_cnt_d = sat_inc(bubble_cnt_q);
    if (drop_evt) drop_cnt_d = sat_inc(drop_cnt_q);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bubble_cnt_q <= '0;
      drop_cnt_q   <= '0;
    end else begin
      bubble_cnt_q <= bubble_cnt_d;
      drop_cnt_q   <= drop_cnt_d;
    end
  end

  assign perfBubbleCnt = bubble_cnt_q;
  assign perfDropCnt   = drop_cnt_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_fetch_ctrl.sv
`default_nettype none
// ============================================================================
// tb_fetch_ctrl : directed + random bench for fetch_ctrl against a queue model
// Rev 1.0
// ============================================================================
module tb_fetch_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        PCsrcE;
  logic [31:0] PCplusImmE;
  logic        stallD;
  logic        imemReq;
  logic [31:0] imemAddr;
  logic        imemReady;
  logic [31:0] imemRdata;
  logic [31:0] instrD;
  logic [31:0] PCD;
  logic        validD;
`ifdef FETCH_PERF_EN
  logic [31:0] perfBubbleCnt;
  logic [31:0] perfDropCnt;
`endif

  int checks = 0;
  int errors = 0;

  fetch_ctrl #(.RESET_PC(32'h0000_0000)) dut (
    .clk        (clk),
    .rst        (rst),
    .PCsrcE     (PCsrcE),
    .PCplusImmE (PCplusImmE),
    .stallD     (stallD),
    .imemReq    (imemReq),
    .imemAddr   (imemAddr),
    .imemReady  (imemReady),
    .imemRdata  (imemRdata),
    .instrD     (instrD),
    .PCD        (PCD),
    .validD     (validD)
`ifdef FETCH_PERF_EN
    ,
    .perfBubbleCnt (perfBubbleCnt),
    .perfDropCnt   (perfDropCnt)
`endif
  );

  always #5 clk = ~clk;

  // Reference model: what the fetch unit must present after each edge
  logic [31:0] m_pc, m_target, m_instr, m_pcd;
  bit          m_req, m_idle, m_discard, m_valid, m_zero;
  logic [63:0] m_skid[$];
  logic [31:0] m_bub, m_drop;
  logic [31:0] last_rdata, held_data;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_pc = 32'h0; m_target = 32'h0; m_instr = 32'h0; m_pcd = 32'h0;
    m_req = 0; m_idle = 1; m_discard = 0; m_valid = 0; m_zero = 1;
    m_skid.delete();
    m_bub = 0; m_drop = 0;
  endtask

  task automatic model_step();
    bit accept, dropped;
    accept  = m_req && imemReady;
    dropped = 0;
    if (!m_idle && !m_valid && m_bub != 32'hFFFF_FFFF) m_bub++;
    if (PCsrcE) begin
      m_instr = 0; m_pcd = 0; m_valid = 0; m_zero = 1;
      m_skid.delete();
      if (m_discard) begin
        if (imemReady) begin m_discard = 0; m_pc = PCplusImmE; dropped = 1; end
        else m_target = PCplusImmE;
      end else if (m_req && !imemReady) begin
        m_discard = 1; m_target = PCplusImmE;
      end else begin
        dropped = accept; m_pc = PCplusImmE; m_req = 1; m_idle = 0;
      end
    end else if (m_idle) begin
      m_idle = 0; m_req = 1;
    end else if (m_discard) begin
      if (imemReady) begin m_discard = 0; m_pc = m_target; dropped = 1; end
    end else if (m_skid.size() != 0) begin
      if (!stallD) begin
        {m_instr, m_pcd} = m_skid.pop_front();
        m_valid = 1; m_zero = 0; m_req = 1;
      end
    end else if (accept) begin
      if (stallD) begin
        m_skid.push_back({imemRdata, m_pc});
        m_req = 0;
      end else begin
        m_instr = imemRdata; m_pcd = m_pc; m_valid = 1; m_zero = 0;
      end
      m_pc = m_pc + 32'd4;
    end else if (!stallD) begin
      m_valid = 0; m_zero = 0;
    end
    if (dropped && m_drop != 32'hFFFF_FFFF) m_drop++;
  endtask

  task automatic check_outputs();
    chk("imemReq", {31'b0, imemReq}, {31'b0, m_req});
    if (m_req) chk("imemAddr", imemAddr, m_pc);
    chk("validD", {31'b0, validD}, {31'b0, m_valid});
    if (m_valid || m_zero) begin
      chk("instrD", instrD, m_instr);
      chk("PCD", PCD, m_pcd);
    end
`ifdef FETCH_PERF_EN
    chk("perfBubbleCnt", perfBubbleCnt, m_bub);
    chk("perfDropCnt", perfDropCnt, m_drop);
`endif
  endtask

  // Called at posedge+1; leaves at the next posedge+1
  task automatic cycle(input logic rdy, input logic stl, input logic br, input logic [31:0] tgt);
    imemReady  = rdy;
    stallD     = stl;
    PCsrcE     = br;
    PCplusImmE = tgt;
    imemRdata  = $urandom;
    last_rdata = imemRdata;
    @(negedge clk);
    check_outputs();
    model_step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; PCsrcE = 0; PCplusImmE = 0; stallD = 0; imemReady = 0; imemRdata = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_imemReq", {31'b0, imemReq}, 32'd0);
    chk("rst_imemAddr", imemAddr, 32'h0);
    chk("rst_validD", {31'b0, validD}, 32'd0);
    chk("rst_instrD", instrD, 32'h0);
    chk("rst_PCD", PCD, 32'h0);
    rst = 1'b0;
    model_reset();

    // Streaming with ready tied high
    cycle(1, 0, 0, 0);
    for (int i = 0; i < 4; i++) begin
      cycle(1, 0, 0, 0);
      chk("stream_addr", imemAddr, 32'(4 * (i + 1)));
      chk("stream_PCD", PCD, 32'(4 * i));
      chk("stream_valid", {31'b0, validD}, 32'd1);
    end

    // Wait states at 0x10
    for (int i = 0; i < 3; i++) begin
      cycle(0, 0, 0, 0);
      chk("wait_addr", imemAddr, 32'h10);
      chk("wait_req", {31'b0, imemReq}, 32'd1);
    end
    cycle(1, 0, 0, 0);
    chk("wait_instr", instrD, last_rdata);
    chk("wait_PCD", PCD, 32'h10);

    // Stall while 0x20 completes
    repeat (3) cycle(1, 0, 0, 0);
    cycle(1, 1, 0, 0);
    held_data = last_rdata;
    chk("hold_req", {31'b0, imemReq}, 32'd0);
    chk("hold_PCD", PCD, 32'h1C);
    cycle(1, 1, 0, 0);
    chk("hold_req2", {31'b0, imemReq}, 32'd0);
    cycle(1, 0, 0, 0);
    chk("unhold_PCD", PCD, 32'h20);
    chk("unhold_instr", instrD, held_data);
    chk("unhold_addr", imemAddr, 32'h24);

    // Redirect while 0x30 outstanding
    repeat (3) cycle(1, 0, 0, 0);
    cycle(0, 0, 1, 32'h100);
    chk("disc_addr", imemAddr, 32'h30);
    chk("disc_valid", {31'b0, validD}, 32'd0);
    cycle(0, 0, 0, 0);
    chk("disc_req", {31'b0, imemReq}, 32'd1);
    cycle(1, 0, 0, 0);
    chk("disc_target", imemAddr, 32'h100);
    chk("disc_gap_valid", {31'b0, validD}, 32'd0);
    cycle(1, 0, 0, 0);
    chk("disc_PCD", PCD, 32'h100);

    // Flush beats stall with full skid
    cycle(1, 1, 0, 0);
    cycle(0, 1, 1, 32'h200);
    chk("flush_instr", instrD, 32'h0);
    chk("flush_PCD", PCD, 32'h0);
    chk("flush_addr", imemAddr, 32'h200);
    cycle(1, 0, 0, 0);
    chk("flush_next_PCD", PCD, 32'h200);

    // Redirect on a ready cycle, then last-redirect-wins in discard
    cycle(1, 0, 1, 32'h300);
    chk("rdy_redir_addr", imemAddr, 32'h300);
    cycle(0, 0, 1, 32'h400);
    cycle(0, 0, 1, 32'h500);
    cycle(1, 0, 0, 0);
    chk("last_wins_addr", imemAddr, 32'h500);

    // PC wrap
    cycle(1, 0, 1, 32'hFFFF_FFFC);
    cycle(1, 0, 0, 0);
    chk("wrap_addr", imemAddr, 32'h0);
    chk("wrap_PCD", PCD, 32'hFFFF_FFFC);

    // Asynchronous reset mid-handshake
    cycle(1, 0, 0, 0);
    cycle(0, 0, 0, 0);
    #2 rst = 1'b1;
    #1;
    chk("arst_req", {31'b0, imemReq}, 32'd0);
    chk("arst_addr", imemAddr, 32'h0);
    chk("arst_valid", {31'b0, validD}, 32'd0);
    chk("arst_instr", instrD, 32'h0);
    chk("arst_PCD", PCD, 32'h0);
`ifdef FETCH_PERF_EN
    chk("arst_bubble", perfBubbleCnt, 32'h0);
    chk("arst_drop", perfDropCnt, 32'h0);
`endif
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      cycle(1'($urandom_range(0, 9) < 7),
            1'($urandom_range(0, 9) < 2),
            1'($urandom_range(0, 11) == 0),
            $urandom & 32'hFFFF_FFFC);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
